// File: rtl/smash_vc_fifo_if.sv
// smash_vc_fifo_if: write/read handshake, flit data and per-VC status bundle; master drives i_*, slave (the buffer) drives o_*
interface smash_vc_fifo_if #(
  parameter int NUM_VC = 2,
  parameter int ADDR_SIZE_FIFO = 2,
  parameter int DATA_SIZE = 32
);
  localparam int VC_BITS = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = ADDR_SIZE_FIFO + 1;
  logic i_write;
  logic [VC_BITS-1:0] i_wr_vc;
  logic [DATA_SIZE-1:0] i_data;
  logic i_read;
  logic [VC_BITS-1:0] i_rd_vc;
  logic [DATA_SIZE-1:0] o_data;
  logic [NUM_VC-1:0] o_full;
  logic [NUM_VC-1:0] o_empty;
  logic [NUM_VC-1:0] o_almost_full;
  logic [NUM_VC*CNT_W-1:0] o_count;
  logic o_wr_err;
  logic o_rd_err;
  modport master (
    output i_write, i_wr_vc, i_data, i_read, i_rd_vc,
    input o_data, o_full, o_empty, o_almost_full, o_count, o_wr_err, o_rd_err
  );
  modport slave (
    input i_write, i_wr_vc, i_data, i_read, i_rd_vc,
    output o_data, o_full, o_empty, o_almost_full, o_count, o_wr_err, o_rd_err
  );
endinterface

// File: rtl/smash_vc_fifo.sv
// smash_vc_fifo: NUM_VC circular FWFT queues sharing one write and one read port; ports i_clk, i_rst (async high), s (slave: VC-steered write/read, head flit, per-VC full/empty/almost-full/count, dropped-access error pulses)
module smash_vc_fifo #(
  parameter int NUM_VC = 2,
  parameter int ADDR_SIZE_FIFO = 2,
  parameter int DATA_SIZE = 32,
  parameter int AFULL_THRESH = 1
) (
  input logic i_clk,
  input logic i_rst,
  smash_vc_fifo_if.slave s
);
  localparam int DEPTH = 1 << ADDR_SIZE_FIFO;
  localparam int VC_BITS = NUM_VC > 1 ? $clog2(NUM_VC) : 1;
  localparam int CNT_W = ADDR_SIZE_FIFO + 1;
  logic [DATA_SIZE-1:0] mem [NUM_VC][DEPTH];
  logic [ADDR_SIZE_FIFO-1:0] wp [NUM_VC];
  logic [ADDR_SIZE_FIFO-1:0] rp [NUM_VC];
  logic [CNT_W-1:0] cnt [NUM_VC];
  logic [NUM_VC-1:0] full, empty, wsel, rsel;
  logic wr_ok, rd_ok, wr_acc, rd_acc;
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign full[v] = cnt[v] == CNT_W'(DEPTH);
    assign empty[v] = cnt[v] == '0;
    assign s.o_almost_full[v] = (DEPTH - int'(cnt[v])) <= AFULL_THRESH;
    assign s.o_count[v*CNT_W +: CNT_W] = cnt[v];
    assign wsel[v] = wr_acc && s.i_wr_vc == VC_BITS'(v);
    assign rsel[v] = rd_acc && s.i_rd_vc == VC_BITS'(v);
  end
  assign s.o_full = full;
  assign s.o_empty = empty;
  assign wr_ok = 32'(s.i_wr_vc) < NUM_VC;
  assign rd_ok = 32'(s.i_rd_vc) < NUM_VC;
  assign rd_acc = s.i_read && rd_ok && !empty[s.i_rd_vc];
  // a full queue still takes a write when the same queue is popped this cycle
  assign wr_acc = s.i_write && wr_ok && (!full[s.i_wr_vc] || (rd_acc && s.i_rd_vc == s.i_wr_vc));
  assign s.o_data = (rd_ok && !empty[s.i_rd_vc]) ? mem[s.i_rd_vc][rp[s.i_rd_vc]] : '0;
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[s.i_wr_vc][wp[s.i_wr_vc]] <= s.i_data;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wp[v] <= '0;
        rp[v] <= '0;
        cnt[v] <= '0;
      end
      s.o_wr_err <= 1'b0;
      s.o_rd_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wsel[v]) wp[v] <= wp[v] + 1'b1;
        if (rsel[v]) rp[v] <= rp[v] + 1'b1;
        cnt[v] <= (wsel[v] && !rsel[v]) ? cnt[v] + 1'b1 :
                  (rsel[v] && !wsel[v]) ? cnt[v] - 1'b1 : cnt[v];
      end
      s.o_wr_err <= s.i_write && !wr_acc;
      s.o_rd_err <= s.i_read && !rd_acc;
    end
  end
endmodule
